lab2_proc_test_mem_responder: RTL
=================================

# lab2_proc_test_mem_responder

Single-port memory responder that terminates the `mem_req_4B_t`/`mem_resp_4B_t` val/rdy protocol driven by the pipelined processor's imem or dmem port. It accepts one request per cycle, performs the read/write against an internal word array, and returns an in-order response after a fixed, parameterized latency. Buffering and credit-based backpressure let it sustain full throughput. It sits in the processor test harness and simple SoC tiles in place of the behavioural test memory.

## Interface
- p_mem_nwords, 256: depth of the word array; must be a power of two, at least 4.
- p_latency, 0: extra response delay in cycles; legal range 0..7.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset asserted.
- memreq_msg  input  $bits(mem_req_4B_t)  request: type_, opaque, addr, len, data.
- memreq_val  input  1  request valid.
- memreq_rdy  output  1  request ready.
- memresp_msg  output  $bits(mem_resp_4B_t)  response: type_, opaque, test, len, data.
- memresp_val  output  1  response valid.
- memresp_rdy  input  1  response ready.

## Operation
- A request fires in any cycle where memreq_val && memreq_rdy.
- Word index is addr[log2(p_mem_nwords)+1:2]; higher address bits are ignored, so addresses wrap modulo the array size. The byte offset is addr[1:0].
- len encoding: 0 = 4 bytes, 1 = 1 byte, 2 = 2 bytes, 3 = 3 bytes.
- Only bytes at offset..offset+nbytes-1 that fall within the addressed word are touched. Bytes that would cross the word boundary are dropped on write and read as zero.
- READ (type 0): data = the selected bytes shifted down to bit 0, zero-extended to 32 bits.
- WRITE (type 1) and INIT (type 2): byte-enabled write of data[8*nbytes-1:0] into the selected bytes. Response data = 0.
- Any other type: no array update. The response is still returned with data = 0 and test = 2'b11 (error flag).
- Response fields:
  - type_, opaque and len echo the request.
  - test = 0 for legal types.
- The array is read and written in the fire cycle. A later request always observes earlier writes. A READ in the cycle after a WRITE to the same word returns the new data.
- Response path:
  - A delay line of p_latency stages (valid + msg) never stalls.
  - It feeds a normal (non-bypass) response queue of depth p_latency+2. The queue head drives memresp_*.
- Credit counter inflight (0..p_latency+2):
  - +1 on request fire.
  - -1 on response fire.
  - Unchanged when both fire in the same cycle.
- memreq_rdy = reset deasserted && (inflight < p_latency+2). It is combinational from the registered inflight only, never from memresp_rdy. This guarantees the queue never overflows.
- Responses are strictly in request order.
- Array contents are not cleared by reset.

## Timing
- While reset = 0, and in the first cycle after it goes high, the block behaves as follows:
  - memreq_rdy = 0 during reset.
  - memresp_val = 0.
  - inflight = 0.
  - Delay line and queue are emptied.
  - Array writes are inhibited.
  - Then memreq_rdy = 1.
- Latency: a request firing in cycle t produces memresp_val = 1 no earlier than cycle t+1+p_latency. It appears exactly then if the queue is empty.
- Throughput: one request and one response per cycle when memresp_rdy stays high. There is no bubble at any p_latency.
- Backpressure: with memresp_rdy held low, exactly p_latency+2 requests are accepted, then memreq_rdy drops. It rises in the cycle after the first response fires.
- Full condition with simultaneous response fire: memreq_rdy remains 0 in that cycle, because it depends on the registered count. A new request can fire in the next cycle.
- memresp_msg is stable while memresp_val && !memresp_rdy.
- Reset asserted mid-operation: all in-flight and queued responses are discarded. Writes already fired remain in the array.

## Test plan
- p_latency=0: WRITE addr 0x0000_0010 data 0xDEADBEEF len 0, then READ 0x10 len 0 -> write response (type 1, data 0) at t+1; read response data 0xDEADBEEF at t+2; opaque values echoed.
- Subword: WRITE 0x10 len 1 data 0x000000AA, then READ 0x13 len 1 and READ 0x10 len 2 -> data 0x000000DE and 0x0000BEAA.
- p_latency=3 with memresp_rdy low: issue 10 READs -> exactly 5 accepted and memreq_rdy=0. Raise memresp_rdy -> responses arrive in order, one per cycle, with no loss.
- Streaming: 32 back-to-back WRITE/READ pairs with memresp_rdy always 1 at p_latency=2 -> one fire per cycle on each port, each response arriving 3 cycles after its request.
- Address wrap at p_mem_nwords=256: WRITE 0x400 data 0x12345678, READ 0x0 -> 0x12345678. Illegal type 5 -> test=2'b11, data 0, array unchanged.
- Reset mid-stream: drive reset=0 for one cycle while 3 responses are pending -> memresp_val=0 and inflight=0 after reset. A subsequent READ returns data written before the reset.

Source files
------------

// File: rtl/lab2_proc_test_mem_responder.sv
// lab2_proc_test_mem_responder: single-port word memory that terminates the
// mem_req_4B_t / mem_resp_4B_t val/rdy protocol. Requests are serviced in the
// fire cycle. Responses travel through a fixed delay line into an in-order
// queue. A credit counter sized to the queue keeps the queue from overflowing.
module lab2_proc_test_mem_responder #(
  parameter  int unsigned p_mem_nwords = 256,
  parameter  int unsigned p_latency    = 0,
  localparam int unsigned REQ_W        = 77,
  localparam int unsigned RESP_W       = 47
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_W-1:0]  memreq_msg,
  input  logic              memreq_val,
  output logic              memreq_rdy,
  output logic [RESP_W-1:0] memresp_msg,
  output logic              memresp_val,
  input  logic              memresp_rdy
);

  // Request payload: type_, opaque, addr, len, data (MSB to LSB)
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  // Response payload: type_, opaque, test, len, data (MSB to LSB)
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam logic [2:0] TYPE_READ  = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;
  localparam logic [2:0] TYPE_INIT  = 3'd2;

  localparam int unsigned IDX_W   = $clog2(p_mem_nwords);
  localparam int unsigned Q_DEPTH = p_latency + 2;
  localparam int unsigned PTR_W   = $clog2(Q_DEPTH);
  localparam int unsigned CNT_W   = $clog2(Q_DEPTH + 1);

  mem_req_4B_t      req_c;
  mem_resp_4B_t     resp_c;
  logic             req_fire_c;
  logic             resp_fire_c;

  logic [IDX_W-1:0] widx_c;
  logic [1:0]       off_c;
  logic [2:0]       nbytes_c;
  logic [31:0]      wmask_c;
  logic [31:0]      word_c;
  logic [31:0]      rdata_c;
  logic [31:0]      wdata_c;
  logic             legal_c;
  logic             is_wr_c;
  logic             unused_addr_c;

  logic [31:0]      mem_q [p_mem_nwords];

  logic             enq_val_c;
  mem_resp_4B_t     enq_msg_c;

  mem_resp_4B_t     q_mem_q [Q_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  assign req_c         = memreq_msg;
  assign widx_c        = req_c.addr[IDX_W+1:2];
  assign off_c         = req_c.addr[1:0];
  assign unused_addr_c = ^req_c.addr[31:IDX_W+2];

  // Credit-based ready: depends only on reset and the registered credit count
  assign memreq_rdy  = reset && (inflight_q < CNT_W'(Q_DEPTH));
  assign req_fire_c  = memreq_val && memreq_rdy;

  // Queue head drives the response port
  assign memresp_val = reset && (count_q != '0);
  assign memresp_msg = q_mem_q[head_q];
  assign resp_fire_c = memresp_val && memresp_rdy;

  // Byte lane selection clipped to the addressed word, read data and response
  always_comb begin
    nbytes_c = (req_c.len == 2'd0) ? 3'd4 : {1'b0, req_c.len};
    wmask_c  = '0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) >= {1'b0, off_c}) && (3'(i) < ({1'b0, off_c} + nbytes_c))) begin
        wmask_c[8*i +: 8] = 8'hFF;
      end
    end
    word_c  = mem_q[widx_c];
    rdata_c = (word_c & wmask_c) >> {off_c, 3'b000};
    wdata_c = req_c.data << {off_c, 3'b000};
    legal_c = (req_c.type_ == TYPE_READ) || (req_c.type_ == TYPE_WRITE) ||
              (req_c.type_ == TYPE_INIT);
    is_wr_c = (req_c.type_ == TYPE_WRITE) || (req_c.type_ == TYPE_INIT);

    resp_c        = '0;
    resp_c.type_  = req_c.type_;
    resp_c.opaque = req_c.opaque;
    resp_c.len    = req_c.len;
    resp_c.test   = legal_c ? 2'b00 : 2'b11;
    resp_c.data   = (req_c.type_ == TYPE_READ) ? rdata_c : 32'h0;
  end

  // Word array: byte-enabled write in the fire cycle, contents survive reset
  always_ff @(posedge clk) begin
    if (req_fire_c && is_wr_c) begin
      mem_q[widx_c] <= (word_c & ~wmask_c) | (wdata_c & wmask_c);
    end
  end

  generate
    if (p_latency == 0) begin : g_no_delay
      assign enq_val_c = req_fire_c;
      assign enq_msg_c = resp_c;
    end else begin : g_delay
      logic [p_latency-1:0] dl_val_q;
      mem_resp_4B_t         dl_msg_q [p_latency];

      // Non-stalling delay line valid bits, flushed by reset
      always_ff @(posedge clk) begin
        if (!reset) begin
          dl_val_q <= '0;
        end else begin
          dl_val_q[0] <= req_fire_c;
          for (int i = 1; i < int'(p_latency); i++) begin
            dl_val_q[i] <= dl_val_q[i-1];
          end
        end
      end

      // Delay line payload, only meaningful where the matching valid is set
      always_ff @(posedge clk) begin
        dl_msg_q[0] <= resp_c;
        for (int i = 1; i < int'(p_latency); i++) begin
          dl_msg_q[i] <= dl_msg_q[i-1];
        end
      end

      assign enq_val_c = dl_val_q[p_latency-1];
      assign enq_msg_c = dl_msg_q[p_latency-1];
    end
  endgenerate

  // Queue pointer, occupancy and credit next-state
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;

    if (enq_val_c) begin
      tail_d = (tail_q == PTR_W'(Q_DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
    end
    if (resp_fire_c) begin
      head_d = (head_q == PTR_W'(Q_DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
    end

    if (enq_val_c && !resp_fire_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq_val_c && resp_fire_c) begin
      count_d = count_q - CNT_W'(1);
    end

    if (req_fire_c && !resp_fire_c) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!req_fire_c && resp_fire_c) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  // Queue and credit state registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Queue storage; credits guarantee a free slot whenever an entry arrives
  always_ff @(posedge clk) begin
    if (enq_val_c) begin
      q_mem_q[tail_q] <= enq_msg_c;
    end
  end

endmodule
